// File: rtl/sp_ram_arbiter_pkg.sv
// Shared types and constants for the two-master single-port RAM arbiter.
//   NUM_MASTERS : number of request ports
//   req_t       : request payload presented by a master (addr/we/be/wdata)
//   rsp_t       : response payload returned to a master (valid/err/rdata)
package sp_ram_arbiter_pkg;

  localparam int unsigned NUM_MASTERS = 2;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/sp_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a one-bit "last winner" pointer.
//   clk, rst      : clock, async active-high reset
//   req           : per-master request
//   gnt_c         : one-hot grant (combinational, forced low during reset)
//   gnt_any_c     : some master is granted this cycle
//   gnt_id_c      : index of the winner (0 when nobody requests)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt_c,
  output logic       gnt_any_c,
  output logic       gnt_id_c
);

  logic last_q;
  logic win;

  // Winner select: on conflict the master not granted most recently wins.
  always_comb begin
    win       = 1'b0;
    gnt_any_c = 1'b0;
    gnt_c     = 2'b00;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
    gnt_any_c = (|req) & ~rst;
    if (gnt_any_c) begin
      gnt_c = win ? 2'b10 : 2'b01;
    end
  end

  assign gnt_id_c = win;

  // Reset to 1 so master 0 wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (gnt_any_c) begin
      last_q <= win;
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-master OBI-style front end for a single-port word RAM.
//   clk, rst           : clock, async active-high reset
//   m_req_i..m_wdata_i : per-master request channel
//   m_gnt_o            : per-master grant (combinational)
//   m_rvalid_o/err/rdata : per-master response, one cycle after grant
//   ram_*_o            : RAM macro drive; ram_rdata_i is its 1-cycle read data
module sp_ram_arbiter
  import sp_ram_arbiter_pkg::*;
#(
  parameter int unsigned RAM_SIZE       = 256,
  parameter int unsigned ADDR_WIDTH     = ADDR_W,
  parameter int unsigned RAM_ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH     = DATA_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_MASTERS-1:0]               m_req_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]               m_we_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]               m_gnt_o,
  output logic [NUM_MASTERS-1:0]               m_rvalid_o,
  output logic [NUM_MASTERS-1:0]               m_err_o,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata_o,
  output logic                                 ram_en_o,
  output logic [RAM_ADDR_WIDTH-1:0]            ram_addr_o,
  output logic                                 ram_we_o,
  output logic [DATA_WIDTH/8-1:0]              ram_be_o,
  output logic [DATA_WIDTH-1:0]                ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]                ram_rdata_i
);

  logic gnt_any;
  logic gnt_id;
  logic in_range;
  req_t sel;
  rsp_t rsp;

  logic rsp_valid_q;
  logic rsp_id_q;
  logic rsp_err_q;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (m_req_i),
    .gnt_c     (m_gnt_o),
    .gnt_any_c (gnt_any),
    .gnt_id_c  (gnt_id)
  );

  // Winner mux; with no grant gnt_id is 0 so the RAM bus follows master 0.
  always_comb begin
    sel       = '0;
    sel.addr  = ADDR_W'(m_addr_i[gnt_id]);
    sel.we    = m_we_i[gnt_id];
    sel.be    = BE_W'(m_be_i[gnt_id]);
    sel.wdata = DATA_W'(m_wdata_i[gnt_id]);
  end

  // RAM_SIZE is a power of two: in range iff all bits above the RAM index are 0.
  assign in_range = (m_addr_i[gnt_id] >> RAM_ADDR_WIDTH) == '0;

  always_comb begin
    ram_en_o    = gnt_any & in_range;
    ram_we_o    = gnt_any & in_range & sel.we;
    ram_addr_o  = RAM_ADDR_WIDTH'(sel.addr);
    ram_be_o    = (DATA_WIDTH/8)'(sel.be);
    ram_wdata_o = DATA_WIDTH'(sel.wdata);
  end

  // Response tracker, reloaded every cycle from the current grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= gnt_any;
      rsp_id_q    <= gnt_id;
      rsp_err_q   <= gnt_any & ~in_range;
    end
  end

  // Error responses return zero data instead of whatever the idle RAM drives.
  always_comb begin
    rsp       = '0;
    rsp.valid = rsp_valid_q;
    rsp.err   = rsp_err_q;
    rsp.rdata = (rsp_valid_q && !rsp_err_q) ? DATA_W'(ram_rdata_i) : '0;
  end

  always_comb begin
    m_rvalid_o = '0;
    m_err_o    = '0;
    m_rdata_o  = '0;
    for (int k = 0; k < int'(NUM_MASTERS); k++) begin
      if (rsp.valid && (rsp_id_q == 1'(k))) begin
        m_rvalid_o[k] = 1'b1;
        m_err_o[k]    = rsp.err;
        m_rdata_o[k]  = DATA_WIDTH'(rsp.rdata);
      end
    end
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
module tb_sp_ram_arbiter;

  logic              clk;
  logic              rst;
  logic [1:0]        m_req;
  logic [1:0][31:0]  m_addr;
  logic [1:0]        m_we;
  logic [1:0][3:0]   m_be;
  logic [1:0][31:0]  m_wdata;
  logic [1:0]        m_gnt;
  logic [1:0]        m_rvalid;
  logic [1:0]        m_err;
  logic [1:0][31:0]  m_rdata;
  logic              ram_en;
  logic [7:0]        ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  sp_ram_arbiter #(.RAM_SIZE(256), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req),
    .m_addr_i    (m_addr),
    .m_we_i      (m_we),
    .m_be_i      (m_be),
    .m_wdata_i   (m_wdata),
    .m_gnt_o     (m_gnt),
    .m_rvalid_o  (m_rvalid),
    .m_err_o     (m_err),
    .m_rdata_o   (m_rdata),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM macro model: registered read, byte-enabled write.
  logic [31:0] ram_mem [64];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram_mem[ram_addr[7:2]];
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) ram_mem[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Bench-side reference state.
  typedef struct {
    int          port;
    bit          err;
    logic [31:0] data;
    bit          chk;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] gmem [64];
  logic        exp_last;
  int          cyc;
  int          total;
  int          bad;
  bit          mon_en;

  always @(posedge clk) cyc <= cyc + 1;

  // Response scoreboard: every negedge either a due response or silence.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        exp_t e;
        logic [1:0] ev;
        logic [1:0] ee;
        e  = sbq.pop_front();
        ev = (e.port == 1) ? 2'b10 : 2'b01;
        ee = e.err ? ev : 2'b00;
        total++;
        if (m_rvalid !== ev || m_err !== ee) begin
          bad++;
          $display("FAIL rsp_flags cyc=%0d rvalid=%b err=%b want rvalid=%b err=%b",
                   cyc, m_rvalid, m_err, ev, ee);
        end
        if (e.chk) begin
          total++;
          if (m_rdata[e.port] !== e.data) begin
            bad++;
            $display("FAIL rsp_data cyc=%0d port=%0d got=%h want=%h",
                     cyc, e.port, m_rdata[e.port], e.data);
          end
        end
        total++;
        if (m_rdata[1-e.port] !== 32'h0) begin
          bad++;
          $display("FAIL rsp_idle_data cyc=%0d port=%0d got=%h want=0",
                   cyc, 1 - e.port, m_rdata[1-e.port]);
        end
      end else begin
        total++;
        if (m_rvalid !== 2'b00) begin
          bad++;
          $display("FAIL rsp_spurious cyc=%0d rvalid=%b want=00", cyc, m_rvalid);
        end
      end
    end
  end

  function automatic logic [1:0] model_gnt(input logic [1:0] req);
    if (req == 2'b11) return exp_last ? 2'b01 : 2'b10;
    return req;
  endfunction

  // Records the expected response for a predicted grant and updates shadow memory.
  function automatic void model_commit(input logic [1:0] g);
    exp_t        e;
    int          p;
    logic [31:0] a;
    bit          inr;
    if (g == 2'b00) return;
    p   = g[1] ? 1 : 0;
    a   = m_addr[p];
    inr = (a < 32'd256);
    e.port = p;
    e.err  = !inr;
    e.data = inr ? gmem[a[7:2]] : 32'h0;
    e.chk  = !inr || !m_we[p];
    e.due  = cyc + 1;
    sbq.push_back(e);
    if (inr && m_we[p]) begin
      for (int b = 0; b < 4; b++) begin
        if (m_be[p][b]) gmem[a[7:2]][b*8 +: 8] = m_wdata[p][b*8 +: 8];
      end
    end
    exp_last = (p == 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] we, input logic [3:0] be0, input logic [31:0] wd0,
                       input logic [31:0] wd1);
    m_req      = req;
    m_addr[0]  = a0;
    m_addr[1]  = a1;
    m_we       = we;
    m_be[0]    = be0;
    m_be[1]    = 4'hF;
    m_wdata[0] = wd0;
    m_wdata[1] = wd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drive(2'b00, 32'h0, 32'h0, 2'b00, 4'h0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_reset();
    drive(2'b11, 32'h0, 32'h4, 2'b00, 4'hF, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (m_gnt !== 2'b00 || m_rvalid !== 2'b00 || ram_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_state gnt=%b rvalid=%b ram_en=%b want 00/00/0", m_gnt, m_rvalid, ram_en);
    end
    drive(2'b00, 32'h0, 32'h0, 2'b00, 4'h0, 32'h0, 32'h0);
    rst      = 1'b0;
    exp_last = 1'b1;
    mon_en   = 1'b1;
  endtask

  task automatic test_contention();
    logic [1:0] want;
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(2'b11, 32'h0, 32'h4, 2'b00, 4'hF, 32'h0, 32'h0);
      @(negedge clk);
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (m_gnt !== want) begin
        bad++;
        $display("FAIL contention_gnt step=%0d got=%b want=%b", i, m_gnt, want);
      end
      model_commit(model_gnt(m_req));
    end
    idle(2);
  endtask

  task automatic test_write_read();
    tick();
    drive(2'b01, 32'h10, 32'h0, 2'b01, 4'b0011, 32'hDEADBEEF, 32'h0);
    @(negedge clk);
    total++;
    if (m_gnt !== 2'b01 || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h10) begin
      bad++;
      $display("FAIL write_gnt gnt=%b en=%b we=%b addr=%h want 01/1/1/10", m_gnt, ram_en, ram_we, ram_addr);
    end
    model_commit(model_gnt(m_req));
    tick();
    drive(2'b01, 32'h10, 32'h0, 2'b00, 4'hF, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (m_gnt !== 2'b01) begin
      bad++;
      $display("FAIL read_gnt got=%b want=01", m_gnt);
    end
    model_commit(model_gnt(m_req));
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b00, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (m_rvalid[0] !== 1'b1 || m_rdata[0] !== 32'h1122BEEF) begin
      bad++;
      $display("FAIL write_read_data rvalid0=%b got=%h want=1122beef", m_rvalid[0], m_rdata[0]);
    end
    idle(1);
  endtask

  task automatic test_oor_read();
    tick();
    drive(2'b10, 32'h0, 32'h100, 2'b00, 4'hF, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (m_gnt !== 2'b10 || ram_en !== 1'b0) begin
      bad++;
      $display("FAIL oor_read_gnt gnt=%b en=%b want 10/0", m_gnt, ram_en);
    end
    model_commit(model_gnt(m_req));
    idle(2);
  endtask

  task automatic test_oor_write();
    tick();
    drive(2'b01, 32'h100, 32'h0, 2'b01, 4'hF, 32'hFFFFFFFF, 32'h0);
    @(negedge clk);
    total++;
    if (m_gnt !== 2'b01 || ram_en !== 1'b0 || ram_we !== 1'b0) begin
      bad++;
      $display("FAIL oor_write_gnt gnt=%b en=%b we=%b want 01/0/0", m_gnt, ram_en, ram_we);
    end
    model_commit(model_gnt(m_req));
    tick();
    drive(2'b01, 32'h0, 32'h0, 2'b00, 4'hF, 32'h0, 32'h0);
    @(negedge clk);
    model_commit(model_gnt(m_req));
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b00, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (m_rdata[0] !== 32'h5A000000) begin
      bad++;
      $display("FAIL oor_write_mem got=%h want=5a000000", m_rdata[0]);
    end
    idle(1);
  endtask

  task automatic test_single_m1();
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(2'b10, 32'h0, 32'(i * 4), 2'b00, 4'hF, 32'h0, 32'h0);
      @(negedge clk);
      total++;
      if (m_gnt !== 2'b10) begin
        bad++;
        $display("FAIL single_m1_gnt step=%0d got=%b want=10", i, m_gnt);
      end
      model_commit(model_gnt(m_req));
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    tick();
    drive(2'b01, 32'h8, 32'h0, 2'b00, 4'hF, 32'h0, 32'h0);
    @(negedge clk);
    model_commit(model_gnt(m_req));
    tick();
    drive(2'b11, 32'h0, 32'h4, 2'b00, 4'hF, 32'h0, 32'h0);
    rst = 1'b1;
    sbq.delete();
    exp_last = 1'b1;
    @(negedge clk);
    total++;
    if (m_rvalid !== 2'b00 || m_gnt !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_drop rvalid=%b gnt=%b want 00/00", m_rvalid, m_gnt);
    end
    rst = 1'b0;
    #1;
    total++;
    if (m_gnt !== 2'b01) begin
      bad++;
      $display("FAIL reset_mid_rr gnt=%b want=01", m_gnt);
    end
    model_commit(model_gnt(m_req));
    idle(2);
  endtask

  initial begin
    rst       = 1'b1;
    cyc       = 0;
    total     = 0;
    bad       = 0;
    mon_en    = 1'b0;
    exp_last  = 1'b1;
    ram_rdata = 32'h0;
    drive(2'b00, 32'h0, 32'h0, 2'b00, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 64; i++) begin
      gmem[i]    = 32'h5A000000 | (32'(i) * 32'h00010101);
      ram_mem[i] = gmem[i];
    end
    gmem[4]    = 32'h11223344;
    ram_mem[4] = 32'h11223344;

    test_reset();
    test_contention();
    test_write_read();
    test_oor_read();
    test_oor_write();
    test_single_m1();
    test_reset_mid();

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left=%0d want=0", sbq.size());
    end
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
